cci_mpf_shim_wr_arbiter: RTL
============================

// Module: cci_mpf_shim_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one ordered CCI write-request channel (c1Tx) among
//  N_REQ clients, in front of the write-response sort shim. Tags each write's Mdata
//  with the client ID and enforces a per-client outstanding-write credit limit.
//  Routes the sorted c0/c1 write responses back to the owning client.
// PARAMETERS
//  N_REQ            4    number of write clients (>=2, power of 2)
//  ADDR_W           58   line address width
//  DATA_W           512  write data width
//  MDATA_W          16   CCI Mdata width; client Mdata uses low MDATA_W-ID_W bits
//  MAX_OUTSTANDING  64   per-client outstanding-write cap (credit limit)
// PORTS
//  clk             in   1                 clock
//  reset_n         in   1                 async active-low reset
//  req_valid       in   N_REQ             client i has a write request
//  req_ready       out  N_REQ             client i request accepted this cycle
//  req_addr        in   N_REQ*ADDR_W      per-client line address
//  req_mdata       in   N_REQ*(MDATA_W-ID_W) per-client Mdata
//  req_data        in   N_REQ*DATA_W      per-client write data
//  c1TxAlmFull     in   1                 downstream write channel almost full
//  wr_valid        out  1                 write request to sort shim
//  wr_addr         out  ADDR_W            granted address
//  wr_mdata        out  MDATA_W           {client_mdata, client_id}
//  wr_data         out  DATA_W            granted data
//  c0_wrRsp_valid  in   1                 sorted write response on c0
//  c0_wrRsp_mdata  in   MDATA_W           its Mdata
//  c1_wrRsp_valid  in   1                 sorted write response on c1
//  c1_wrRsp_mdata  in   MDATA_W           its Mdata
//  rsp_valid       out  N_REQ*2           [i*2+ch] response for client i on channel ch
//  rsp_mdata       out  2*(MDATA_W-ID_W)  client Mdata per channel (ID stripped)
// BEHAVIOUR
//  ID_W = $clog2(N_REQ); CNT_W = $clog2(MAX_OUTSTANDING+1).
//  Reset (async, any cycle incl. mid-burst): wr_valid=0, rsp_valid=0, req_ready=0,
//   all credit counters=0, RR pointer=N_REQ-1 (client 0 has first priority).
//   Writes in flight at reset are abandoned; late responses do not underflow counters.
//  Eligible(i) = req_valid[i] && cnt[i] < MAX_OUTSTANDING && !c1TxAlmFull.
//  Grant: one per cycle; search starts at ptr+1 mod N_REQ, first eligible wins.
//   req_ready[i] is combinational, asserted only for the winner. ptr <= winner on grant;
//   ptr is unchanged when there is no grant.
//  Output register: wr_* registered from the winner, so wr_valid is high exactly
//   1 cycle after the req_valid&&req_ready handshake. When there is no grant,
//   wr_valid=0 and the data fields hold their last value.
//  Almost-full: c1TxAlmFull is sampled in the grant cycle. At most 1 write (already
//   registered) issues after almFull rises. The downstream scoreboard reserve
//   absorbs it.
//  Tagging: wr_mdata = {req_mdata[i], ID_W'(i)}.
//  Responses: channel ch valid -> client id = mdata[ID_W-1:0]. rsp_valid is
//   combinational, 0 latency; rsp_mdata[ch] = mdata[MDATA_W-1:ID_W].
//   Both channels may target the same client in one cycle; both bits assert.
//  Credit update per cycle:
//   cnt[i] <= cnt[i] + grant[i] - rsp(c0,i) - rsp(c1,i), saturating at 0.
//   Grant and two returns in one cycle net to -1.
//  Counter at MAX_OUTSTANDING blocks that client only; other clients proceed.
//  A response with an out-of-range ID (N_REQ not power of 2 is forbidden) cannot occur.
//  Assertion (sim): cnt[i] never exceeds MAX_OUTSTANDING; no response when cnt=0.
// TESTING
//  1 Reset: hold reset_n=0, all req_valid=1 -> req_ready=0, wr_valid=0;
//    release -> client0 granted first, wr_valid 1 cycle later, wr_mdata[1:0]=0.
//  2 Fairness: N_REQ=4, all valid continuously -> grant order 0,1,2,3,0,...;
//    100 grants split 25 each.
//  3 Credit cap: client2 only, no responses -> exactly 64 grants then req_ready=0;
//    one c0 response id=2 -> exactly one further grant.
//  4 AlmFull: assert c1TxAlmFull mid-stream -> req_ready=0 same cycle, at most 1
//    further wr_valid; deassert -> grants resume next cycle.
//  5 Dual response: c0 and c1 responses both id=1, mdata 0x0005/0x0009 ->
//    rsp_valid[2],[3]=1, rsp_mdata=0x0001/0x0002, cnt[1] -= 2.
//  6 Async reset mid-traffic with cnt[0]=10 -> counters 0 immediately; late
//    response id=0 leaves cnt[0]=0.

Source files
------------

// File: rtl/cci_mpf_shim_wr_arbiter.sv
// cci_mpf_shim_wr_arbiter: round-robin c1Tx write arbiter with per-client credits, Mdata tagging and response routing
module cci_mpf_shim_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 58,
  parameter int DATA_W = 512,
  parameter int MDATA_W = 16,
  parameter int MAX_OUTSTANDING = 64,
  localparam int ID_W = $clog2(N_REQ),
  localparam int CM_W = MDATA_W - ID_W,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*CM_W-1:0]   req_mdata,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    c1TxAlmFull,
  output logic                    wr_valid,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [MDATA_W-1:0]      wr_mdata,
  output logic [DATA_W-1:0]       wr_data,
  input  logic                    c0_wrRsp_valid,
  input  logic [MDATA_W-1:0]      c0_wrRsp_mdata,
  input  logic                    c1_wrRsp_valid,
  input  logic [MDATA_W-1:0]      c1_wrRsp_mdata,
  output logic [N_REQ*2-1:0]      rsp_valid,
  output logic [2*CM_W-1:0]       rsp_mdata
);
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] armed_q, armed_d;
  logic [ID_W-1:0] ptr_q, ptr_d, idx, win;
  logic found;
  logic wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [MDATA_W-1:0] wr_mdata_q, wr_mdata_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W:0] up, dn;
  // Search for the first eligible client starting just after the last winner
  always_comb begin
    idx = '0;
    win = ptr_q;
    found = 1'b0;
    req_ready = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr_q + ID_W'(k);
      if (!found && reset_n && !c1TxAlmFull && req_valid[idx] && cnt_q[idx] < CNT_W'(MAX_OUTSTANDING)) begin
        found = 1'b1;
        win = idx;
      end
    end
    req_ready[win] = found;
    ptr_d = win;
  end
  // Capture the winner's request tagged with its ID; fields hold while idle
  always_comb begin
    wr_valid_d = found;
    wr_addr_d = found ? req_addr[int'(win)*ADDR_W +: ADDR_W] : wr_addr_q;
    wr_mdata_d = found ? {req_mdata[int'(win)*CM_W +: CM_W], win} : wr_mdata_q;
    wr_data_d = found ? req_data[int'(win)*DATA_W +: DATA_W] : wr_data_q;
  end
  // Route each sorted response to the client named in its low Mdata bits
  always_comb begin
    rsp_valid = '0;
    rsp_valid[{c0_wrRsp_mdata[ID_W-1:0], 1'b0}] = reset_n && c0_wrRsp_valid;
    rsp_valid[{c1_wrRsp_mdata[ID_W-1:0], 1'b1}] = reset_n && c1_wrRsp_valid;
    rsp_mdata = {c1_wrRsp_mdata[MDATA_W-1:ID_W], c0_wrRsp_mdata[MDATA_W-1:ID_W]};
  end
  // Net grants against returns per client, clamping at zero for abandoned writes
  always_comb begin
    up = '0;
    dn = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up = {1'b0, cnt_q[i]} + (CNT_W+1)'(req_ready[i]);
      dn = (CNT_W+1)'(rsp_valid[2*i]) + (CNT_W+1)'(rsp_valid[2*i+1]);
      cnt_d[i] = up >= dn ? CNT_W'(up - dn) : '0;
    end
    armed_d = armed_q | req_ready;
  end
  // State and output registers; reset drops all in-flight bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '{default: '0};
      armed_q <= '0;
      ptr_q <= ID_W'(N_REQ - 1);
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_mdata_q <= '0;
      wr_data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      armed_q <= armed_d;
      ptr_q <= ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q <= wr_addr_d;
      wr_mdata_q <= wr_mdata_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign wr_valid = wr_valid_q;
  assign wr_addr = wr_addr_q;
  assign wr_mdata = wr_mdata_q;
  assign wr_data = wr_data_q;
  for (genvar g = 0; g < N_REQ; g++) begin : g_chk
    assert property (@(posedge clk) disable iff (!reset_n) cnt_q[g] <= CNT_W'(MAX_OUTSTANDING));
    assert property (@(posedge clk) disable iff (!reset_n)
      armed_q[g] && (rsp_valid[2*g] || rsp_valid[2*g+1]) |-> cnt_q[g] != '0);
  end
endmodule
